rot_issue_stage: RTL

Pipelined, handshake-driven issue stage that sits directly upstream of the combinational 32-bit right barrel rotator. It accepts rotate commands (data, amount, direction) on a valid/ready input port and converts left rotates into equivalent right-rotate amounts. It drives the rotator's amount and data inputs from a registered stage, captures the rotator's result into an output register, and presents it on a valid/ready output port. It sustains one operation per cycle under no backpressure and counts completed operations.

---
 rtl/rot_issue_stage.sv | 94 +++++++++
 1 files changed

// File: rtl/rot_issue_stage.sv
// rot_issue_stage: two-register issue pipeline feeding a combinational
// right rotator, with valid/ready on the command and result ports.
module rot_issue_stage #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic [4:0]         in_amnt,
  input  logic               in_dir,
  output logic [4:0]         rot_amnt,
  output logic [31:0]        rot_str,
  input  logic [31:0]        rot_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] op_count
);

  logic         s1_valid;
  logic [31:0]  s1_data;
  logic [4:0]   s1_amnt;
  logic         s2_valid;
  logic [31:0]  s2_data;

  logic         s2_free;
  logic         s1_load;
  logic         s1_xfer;
  logic         out_fire;
  logic [4:0]   right_amnt;

  // Handshake qualifiers for both stages
  always_comb begin
    s2_free  = !s2_valid || out_ready;
    in_ready = !s1_valid || s2_free;
    s1_load  = in_valid && in_ready;
    s1_xfer  = s1_valid && s2_free;
    out_fire = s2_valid && out_ready;
  end

  // A left rotate by k is the same as a right rotate by 32-k
  always_comb begin
    right_amnt = in_amnt;
    unique case (1'b1)
      in_dir:  right_amnt = 5'd0 - in_amnt;
      !in_dir: right_amnt = in_amnt;
    endcase
  end

  // Stage 1 holds the command presented to the rotator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_amnt  <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_amnt  <= right_amnt;
    end else if (s1_xfer) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 captures the rotator result and holds it until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s1_xfer) begin
      s2_valid <= 1'b1;
      s2_data  <= rot_result;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Completed-operation counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign rot_str   = s1_data;
  assign rot_amnt  = s1_amnt;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;

endmodule
